// File: rtl/pc_gen.sv
// Stage-1 fetch PC generator with an optional direct-mapped branch target buffer.
// Define PC_GEN_BTB_EN to build the BTB; otherwise prediction is always PC+4.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_2000,
  parameter int              BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  output logic [XLEN-1:0] pc_out,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_next_pc
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign pc_out   = pc_q;

`ifdef PC_GEN_BTB_EN
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic             wr_en, wr_tgt_en;
  logic [1:0]       wr_ctr;
  logic [1:0]       unused_upd_lsb;

  assign rd_idx         = pc_q[IDX+1:2];
  assign rd_tag         = pc_q[XLEN-1:IDX+2];
  assign wr_idx         = update_pc[IDX+1:2];
  assign wr_tag         = update_pc[XLEN-1:IDX+2];
  assign unused_upd_lsb = update_pc[1:0];
  assign rd_hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit         = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Lookup reads the current array contents, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_taken   = rd_hit && ctr_q[rd_idx][1];
    pred_next_pc = pred_taken ? target_q[rd_idx] : pc_plus4;
  end

  always_comb begin
    valid_d   = valid_q;
    wr_en     = 1'b0;
    wr_tgt_en = 1'b0;
    wr_ctr    = ctr_q[wr_idx];
    if (update_valid) begin
      if (wr_hit) begin
        wr_en = 1'b1;
        if (update_taken) begin
          wr_tgt_en = 1'b1;
          wr_ctr    = (ctr_q[wr_idx] == 2'b11) ? 2'b11 : ctr_q[wr_idx] + 2'b01;
        end else begin
          wr_ctr    = (ctr_q[wr_idx] == 2'b00) ? 2'b00 : ctr_q[wr_idx] - 2'b01;
        end
      end else if (update_taken) begin
        wr_en           = 1'b1;
        wr_tgt_en       = 1'b1;
        wr_ctr          = 2'b10;
        valid_d[wr_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // Entry payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      ctr_q[wr_idx] <= wr_ctr;
      if (wr_tgt_en) target_q[wr_idx] <= update_target;
    end
  end
`else
  localparam int unused_btb_entries = BTB_ENTRIES;
  logic unused_update;

  assign unused_update = ^{update_valid, update_pc, update_target, update_taken};
  assign pred_taken    = 1'b0;
  assign pred_next_pc  = pc_plus4;
`endif

  // Redirect beats stall; otherwise follow the prediction.
  always_comb begin
    pc_d = pred_next_pc;
    if (redirect_valid) pc_d = redirect_target;
    else if (stall)     pc_d = pc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= RESET_VECTOR;
    else          pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a reference BTB model feeds a scoreboard queue of
// post-edge expectations, and the combinational prediction is checked before each edge.
module tb_pc_gen;
  localparam int N   = 16;
  localparam int IDX = 4;
  localparam logic [31:0] RV = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic [31:0] update_target = '0;
  logic        update_taken = 1'b0;
  logic [31:0] pc_out;
  logic        pred_taken;
  logic [31:0] pred_next_pc;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .pc_out(pc_out), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0]      m_pc;
  logic             m_valid [N];
  logic [31-IDX-2:0] m_tag  [N];
  logic [31:0]      m_tgt   [N];
  int               m_ctr   [N];

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] npc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void predict(input logic [31:0] pc, output logic tk, output logic [31:0] npc);
`ifdef PC_GEN_BTB_EN
    int i;
    i   = int'(pc[IDX+1:2]);
    tk  = m_valid[i] && (m_tag[i] == pc[31:IDX+2]) && (m_ctr[i] >= 2);
    npc = tk ? m_tgt[i] : pc + 32'd4;
`else
    tk  = 1'b0;
    npc = pc + 32'd4;
`endif
  endfunction

  function automatic void train(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn);
`ifdef PC_GEN_BTB_EN
    int i;
    logic hit;
    i   = int'(pc[IDX+1:2]);
    hit = m_valid[i] && (m_tag[i] == pc[31:IDX+2]);
    if (hit && tkn) begin
      if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
      m_tgt[i] = tgt;
    end else if (hit) begin
      if (m_ctr[i] > 0) m_ctr[i] = m_ctr[i] - 1;
    end else if (tkn) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:IDX+2];
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2;
    end
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_pc = RV;
  endfunction

  // One clock: drive at negedge, check current prediction, push expectation, compare after edge.
  task automatic step(input logic rv, input logic [31:0] rt, input logic st,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic utk);
    logic        tk;
    logic [31:0] npc;
    exp_t        e;
    redirect_valid = rv; redirect_target = rt; stall = st;
    update_valid = uv; update_pc = upc; update_target = utgt; update_taken = utk;
    #1;
    predict(m_pc, tk, npc);
    chk("pred_taken_pre", {31'd0, pred_taken}, {31'd0, tk});
    chk("pred_next_pre", pred_next_pc, npc);
    m_pc = rv ? rt : (st ? m_pc : npc);
    if (uv) train(upc, utgt, utk);
    e.pc = m_pc;
    predict(m_pc, e.tk, e.npc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc_out", pc_out, e.pc);
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.tk});
    chk("pred_next_pc", pred_next_pc, e.npc);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic redir(input logic [31:0] t);
    step(1'b1, t, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic upd_stall(input logic [31:0] upc, input logic [31:0] tgt, input logic tkn);
    step(1'b0, 32'h0, 1'b1, 1'b1, upc, tgt, tkn);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_out, RV);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_next", pred_next_pc, RV + 32'd4);
    reset_n = 1'b1;

    // Sequential fetch, then stall and stall-with-redirect.
    idle(2);
    chk("seq_2008", pc_out, 32'h2008);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("stall_hold", pc_out, 32'h2008);
    step(1'b1, 32'h3000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("redir_over_stall", pc_out, 32'h3000);

    // Allocate 0x2010 -> 0x2400 and fetch into it.
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h2010, 32'h2400, 1'b1);
    redir(32'h2008);
    idle(2);
    chk("at_2010", pc_out, 32'h2010);
`ifdef PC_GEN_BTB_EN
    chk("alloc_pred", pred_next_pc, 32'h2400);
`else
    chk("alloc_pred", pred_next_pc, 32'h2014);
`endif
    idle(1);

    // Counter hysteresis while parked on 0x2010 (same-cycle update is read-before-write).
    redir(32'h2010);
    upd_stall(32'h2010, 32'h2400, 1'b0);
    chk("ctr1_next", pred_next_pc, 32'h2014);
    upd_stall(32'h2010, 32'h2400, 1'b1);
    upd_stall(32'h2010, 32'h2400, 1'b1);
    repeat (4) upd_stall(32'h2010, 32'h2400, 1'b0);
    chk("ctr0_taken", {31'd0, pred_taken}, 32'd0);

    // Aliasing: 0x2050 shares the index of 0x2010, update_pc low bits ignored.
    upd_stall(32'h2010, 32'h2400, 1'b1);
    upd_stall(32'h2051, 32'h2600, 1'b1);
    redir(32'h2010);
    chk("alias_old_miss", pred_next_pc, 32'h2014);
    redir(32'h2050);
    idle(1);
    upd_stall(32'h2053, 32'h2700, 1'b1);
    redir(32'h2050);
    idle(1);

    // PC wraps modulo 2^32.
    redir(32'hFFFF_FFFC);
    idle(1);
    chk("wrap_zero", pc_out, 32'h0);

    // Asynchronous reset mid-run discards pending redirect and update.
    redir(32'h2050);
    redirect_valid = 1'b1; redirect_target = 32'h5000;
    update_valid = 1'b1; update_pc = 32'h2004; update_target = 32'h2800; update_taken = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_pc", pc_out, RV);
    chk("async_rst_taken", {31'd0, pred_taken}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_held_pc", pc_out, RV);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    redir(32'h2050);
    chk("rst_cleared_btb", pred_next_pc, 32'h2054);
    redir(32'h2004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
